dpi_timing_gen: RTL and testbench
=================================

// Module: dpi_timing_gen
// PURPOSE
//  Generates DPI/VGA-style raster timing: HSYNC, VSYNC, DE and pixel coordinates.
//  It is the source for the DPI output path and the transmit counterpart of the DPI input sync detector.
//  Its defaults produce 640x480@60 at 25.175 MHz, so a looped-back output passes the detector's freq/width checks.
//  Runs in the pixel clock domain; starts and stops cleanly on frame boundaries.
// PARAMETERS
//  H_ACTIVE   640  visible pixels per line
//  H_FP       16   horizontal front porch, pixels
//  H_SYNC     96   HSYNC pulse width, pixels
//  H_BP       48   horizontal back porch, pixels (H_TOTAL = 800)
//  V_ACTIVE   480  visible lines per frame
//  V_FP       10   vertical front porch, lines
//  V_SYNC     2    VSYNC pulse width, lines
//  V_BP       33   vertical back porch, lines (V_TOTAL = 525)
//  HS_POL     0    HSYNC active level (0 = active-low)
//  VS_POL     0    VSYNC active level (0 = active-low)
// PORTS
//  CLK          in   1   pixel clock
//  RESET_N      in   1   asynchronous, active-low reset
//  ENABLE       in   1   level; 1 = run raster, 0 = stop at end of current frame
//  HSYNC        out  1   horizontal sync, polarity HS_POL
//  VSYNC        out  1   vertical sync, polarity VS_POL
//  DE           out  1   data enable: 1 inside the active area
//  PIX_X        out  11  active-area column 0..H_ACTIVE-1; 0 when DE=0
//  PIX_Y        out  11  active-area row 0..V_ACTIVE-1; 0 when DE=0
//  LINE_START   out  1   1-cycle pulse on the first cycle of every line (h=0)
//  FRAME_START  out  1   1-cycle pulse on the first cycle of every frame (h=0, v=0)
//  RUNNING      out  1   1 while the counters advance
// BEHAVIOUR
//  - Counters: h_cnt 0..H_TOTAL-1 wraps to 0 and increments v_cnt; v_cnt 0..V_TOTAL-1 wraps to 0.
//  - Counter widths are 11 bits. Totals must be <= 2047; this is checked in an initial block.
//  - Decode of (h_cnt, v_cnt):
//      de = h < H_ACTIVE && v < V_ACTIVE
//      hs = H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC
//      vs = V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC; VSYNC changes only when h=0.
//  - All outputs are registered, with 1-cycle latency from the counter state. HSYNC, VSYNC, DE, PIX_* and the pulses stay mutually aligned.
//  - FSM states:
//      IDLE: counters held at 0; outputs inactive.
//      RUN:  counters advance every cycle.
//      STOP: counters advance; ENABLE is ignored until end of frame.
//  - FSM transitions:
//      IDLE->RUN when ENABLE=1. The first counting cycle is h=0,v=0, so FRAME_START is guaranteed at start.
//      RUN->STOP when ENABLE=0.
//      STOP->IDLE on the last cycle of the frame (h=H_TOTAL-1, v=V_TOTAL-1).
//      STOP never returns to RUN mid-frame. If ENABLE=1 at that last cycle, the FSM goes to RUN directly and the frame continues seamlessly.
//  - RUNNING=1 in RUN and STOP.
//  - In IDLE: HSYNC=~HS_POL, VSYNC=~VS_POL (inactive), DE=0, PIX_X=PIX_Y=0, pulses 0.
//  - Reset (async assert, any time incl. mid-frame): state IDLE, counters 0, all outputs at their IDLE values.
//  - Reset deassertion is synchronous to CLK via an external reset synchronizer.
//  - ENABLE is synchronous to CLK; a 1-cycle ENABLE pulse from IDLE yields exactly one full frame.
// STRUCTURE
//  - Include file dpi_timing_defs.vh holds the 640x480@60 timing constants and the FSM state encodings. It is shared with the sync detector configuration.
//  - Sub-module dpi_axis_counter: a wrap counter with parameters ACTIVE/FP/SYNC/BP.
//      Inputs: clk, rst_n, clr, inc.
//      Outputs: cnt, wrap (terminal count), active, sync.
//      Instantiated twice: H with inc=running; V with inc=running & h_wrap.
//  - Top level holds the FSM, output registers and polarity application.
// TESTING
//  1. Reset, ENABLE=0 for 100 cycles -> DE=0, HSYNC=VSYNC=1, PIX_*=0, RUNNING=0.
//  2. ENABLE=1, run 2 frames:
//      - 640 DE cycles per line; 480 DE lines per frame; 800 cycles between LINE_START pulses; 420000 cycles between FRAME_START pulses.
//      - HSYNC low for 96 cycles starting 656 cycles after LINE_START.
//      - VSYNC low for 2 lines (1600 cycles) starting at line 490.
//  3. Drop ENABLE at line 100 -> frame completes to line 524, col 799. The next cycle shows RUNNING=0, with no FRAME_START and no partial frame.
//  4. 1-cycle ENABLE pulse from IDLE -> exactly 1 FRAME_START, 480x640 DE cycles, then IDLE.
//  5. Assert RESET_N=0 at line 300, col 200 -> outputs inactive immediately (async). After release with ENABLE=1, FRAME_START is at h=0,v=0.
//  6. Small parameters (4/1/2/1, 3/1/1/1), HS_POL=VS_POL=1 -> scoreboard checks every cycle over 3 frames. PIX_X/PIX_Y sweep 0..3/0..2 with active-high syncs.

Source files
------------

// File: rtl/dpi_timing_gen_pkg.sv
// Shared raster timing constants (640x480@60 defaults) and FSM state encoding
// for the DPI timing generator and its companion sync detector configuration.
package dpi_timing_gen_pkg;

  localparam int unsigned CW        = 11;
  localparam int unsigned MAX_TOTAL = 2047;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } state_t;

endpackage

// File: rtl/dpi_axis_counter.sv
// One raster axis: wrap counter with combinational active/sync region decode.
module dpi_axis_counter
  import dpi_timing_gen_pkg::*;
#(
  parameter int unsigned ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned FP     = DEF_H_FP,
  parameter int unsigned SYNC   = DEF_H_SYNC,
  parameter int unsigned BP     = DEF_H_BP
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] cnt,
  output logic          wrap,
  output logic          active,
  output logic          sync
);

  localparam int unsigned TOTAL      = ACTIVE + FP + SYNC + BP;
  localparam int unsigned SYNC_START = ACTIVE + FP;
  localparam int unsigned SYNC_END   = ACTIVE + FP + SYNC;

  assign wrap   = (cnt == CW'(TOTAL - 1));
  assign active = (cnt < CW'(ACTIVE));
  assign sync   = (cnt >= CW'(SYNC_START)) && (cnt < CW'(SYNC_END));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= wrap ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/dpi_timing_gen.sv
// DPI/VGA raster timing source: FSM, H/V axis counters and registered,
// polarity-adjusted sync/DE/coordinate outputs; starts and stops on frame edges.
module dpi_timing_gen
  import dpi_timing_gen_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [CW-1:0] pix_x,
  output logic [CW-1:0] pix_y,
  output logic          line_start,
  output logic          frame_start,
  output logic          running
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Counters are CW bits wide; larger rasters cannot be represented.
  if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_bad_total
    $error("dpi_timing_gen: H_TOTAL/V_TOTAL exceed counter range");
  end

  state_t        state;
  logic          run_c;
  logic [CW-1:0] h_cnt, v_cnt;
  logic          h_wrap, v_wrap, h_act, v_act, h_sync, v_sync;
  logic          frame_end_c;

  assign run_c       = (state != ST_IDLE);
  assign frame_end_c = h_wrap & v_wrap;

  dpi_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)
  ) u_h (
    .clk(clk), .rst_n(rst_n), .clr(~run_c), .inc(run_c),
    .cnt(h_cnt), .wrap(h_wrap), .active(h_act), .sync(h_sync)
  );

  dpi_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)
  ) u_v (
    .clk(clk), .rst_n(rst_n), .clr(~run_c), .inc(run_c & h_wrap),
    .cnt(v_cnt), .wrap(v_wrap), .active(v_act), .sync(v_sync)
  );

  // FSM plus output registers; outputs trail the counter state by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      de          <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      running     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (enable) state <= ST_RUN;
        ST_RUN:  if (!enable) state <= ST_STOP;
        ST_STOP: if (frame_end_c) state <= enable ? ST_RUN : ST_IDLE;
        default: state <= ST_IDLE;
      endcase

      if (run_c) begin
        hsync       <= h_sync ? HS_POL : ~HS_POL;
        vsync       <= v_sync ? VS_POL : ~VS_POL;
        de          <= h_act & v_act;
        pix_x       <= (h_act & v_act) ? h_cnt : '0;
        pix_y       <= (h_act & v_act) ? v_cnt : '0;
        line_start  <= (h_cnt == '0);
        frame_start <= (h_cnt == '0) && (v_cnt == '0);
        running     <= 1'b1;
      end else begin
        hsync       <= ~HS_POL;
        vsync       <= ~VS_POL;
        de          <= 1'b0;
        pix_x       <= '0;
        pix_y       <= '0;
        line_start  <= 1'b0;
        frame_start <= 1'b0;
        running     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dpi_timing_gen.sv
// Directed bench for dpi_timing_gen: default 640x480 timing, a medium raster
// for frame-level start/stop behaviour, and a tiny active-high raster scoreboard.
module tb_dpi_timing_gen;

  logic clk;
  logic rst_n;
  logic en_d, en_m, en_s;

  logic        d_hs, d_vs, d_de, d_ls, d_fs, d_run;
  logic [10:0] d_px, d_py;
  logic        m_hs, m_vs, m_de, m_ls, m_fs, m_run;
  logic [10:0] m_px, m_py;
  logic        s_hs, s_vs, s_de, s_ls, s_fs, s_run;
  logic [10:0] s_px, s_py;

  int passed;
  int total;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  dpi_timing_gen dut_d (
    .clk(clk), .rst_n(rst_n), .enable(en_d),
    .hsync(d_hs), .vsync(d_vs), .de(d_de), .pix_x(d_px), .pix_y(d_py),
    .line_start(d_ls), .frame_start(d_fs), .running(d_run)
  );

  // H total 15 (sync at 10..12), V total 10 (sync at lines 6..7), active-low
  dpi_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(5), .V_FP(1), .V_SYNC(2), .V_BP(2)
  ) dut_m (
    .clk(clk), .rst_n(rst_n), .enable(en_m),
    .hsync(m_hs), .vsync(m_vs), .de(m_de), .pix_x(m_px), .pix_y(m_py),
    .line_start(m_ls), .frame_start(m_fs), .running(m_run)
  );

  dpi_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) dut_s (
    .clk(clk), .rst_n(rst_n), .enable(en_s),
    .hsync(s_hs), .vsync(s_vs), .de(s_de), .pix_x(s_px), .pix_y(s_py),
    .line_start(s_ls), .frame_start(s_fs), .running(s_run)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en_d = 1'b0; en_m = 1'b0; en_s = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    repeat (100) step();
    total++; if ({d_hs, d_vs, d_de, d_ls, d_fs, d_run} !== 6'b110000)
      $display("FAIL reset_d_ctrl got=%b exp=110000", {d_hs, d_vs, d_de, d_ls, d_fs, d_run}); else passed++;
    total++; if ({d_px, d_py} !== 22'd0)
      $display("FAIL reset_d_pix got=%0d,%0d exp=0,0", d_px, d_py); else passed++;
    total++; if ({m_hs, m_vs, m_de, m_ls, m_fs, m_run} !== 6'b110000)
      $display("FAIL reset_m_ctrl got=%b exp=110000", {m_hs, m_vs, m_de, m_ls, m_fs, m_run}); else passed++;
    total++; if ({s_hs, s_vs, s_de, s_ls, s_fs, s_run} !== 6'b000000)
      $display("FAIL reset_s_ctrl got=%b exp=000000", {s_hs, s_vs, s_de, s_ls, s_fs, s_run}); else passed++;
    total++; if ({s_px, s_py} !== 22'd0)
      $display("FAIL reset_s_pix got=%0d,%0d exp=0,0", s_px, s_py); else passed++;
  endtask

  task automatic test_default_lines();
    int de_cnt = 0, ls_cnt = 0, gap_bad = 0, last_ls = -1;
    int hs_first = -1, hs_low = 0, vs_low = 0, fs_cnt = 0;
    logic [10:0] px639 = '0, px640 = '1, py1700 = '0;
    en_d = 1'b1;
    step();
    step();
    total++; if ({d_fs, d_ls, d_de, d_run} !== 4'b1111)
      $display("FAIL first_cycle_d got=%b exp=1111", {d_fs, d_ls, d_de, d_run}); else passed++;
    for (int k = 0; k < 2400; k++) begin
      if (k > 0) step();
      if (d_de) de_cnt++;
      if (d_ls) begin
        ls_cnt++;
        if (last_ls >= 0 && (k - last_ls) != 800) gap_bad++;
        last_ls = k;
      end
      if (!d_hs) begin
        hs_low++;
        if (hs_first < 0) hs_first = k;
      end
      if (!d_vs) vs_low++;
      if (d_fs) fs_cnt++;
      if (k == 639) px639 = d_px;
      if (k == 640) px640 = d_px;
      if (k == 1700) py1700 = d_py;
    end
    total++; if (de_cnt != 1920) $display("FAIL d_de_count got=%0d exp=1920", de_cnt); else passed++;
    total++; if (ls_cnt != 3) $display("FAIL d_line_starts got=%0d exp=3", ls_cnt); else passed++;
    total++; if (gap_bad != 0 || last_ls != 1600)
      $display("FAIL d_line_period bad=%0d last=%0d exp=0,1600", gap_bad, last_ls); else passed++;
    total++; if (hs_first != 656) $display("FAIL d_hs_start got=%0d exp=656", hs_first); else passed++;
    total++; if (hs_low != 288) $display("FAIL d_hs_width got=%0d exp=288", hs_low); else passed++;
    total++; if (vs_low != 0) $display("FAIL d_vs_early got=%0d exp=0", vs_low); else passed++;
    total++; if (fs_cnt != 1) $display("FAIL d_frame_starts got=%0d exp=1", fs_cnt); else passed++;
    total++; if (px639 !== 11'd639) $display("FAIL d_pix_x_last got=%0d exp=639", px639); else passed++;
    total++; if (px640 !== 11'd0) $display("FAIL d_pix_x_blank got=%0d exp=0", px640); else passed++;
    total++; if (py1700 !== 11'd2) $display("FAIL d_pix_y got=%0d exp=2", py1700); else passed++;
  endtask

  task automatic test_reset_midframe();
    repeat (201) step();
    total++; if ({d_px, d_py} !== {11'd200, 11'd3})
      $display("FAIL d_pos_before_reset got=%0d,%0d exp=200,3", d_px, d_py); else passed++;
    rst_n = 1'b0;
    #2;
    total++; if ({d_hs, d_vs, d_de, d_ls, d_fs, d_run, d_px, d_py} !== {6'b110000, 22'd0})
      $display("FAIL d_async_reset got=%b exp=110000 pix=0", {d_hs, d_vs, d_de, d_ls, d_fs, d_run}); else passed++;
    step();
    rst_n = 1'b1;
    step();
    total++; if ({d_run, d_fs} !== 2'b00)
      $display("FAIL d_post_reset_idle got=%b exp=00", {d_run, d_fs}); else passed++;
    step();
    total++; if ({d_fs, d_ls, d_de, d_run, d_px, d_py} !== {4'b1111, 22'd0})
      $display("FAIL d_restart got=%b pix=%0d,%0d exp=1111 pix=0,0", {d_fs, d_ls, d_de, d_run}, d_px, d_py); else passed++;
    rst_n = 1'b0;
    en_d  = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_frames_and_stop();
    int de_cnt = 0, fs_cnt = 0, ls_cnt = 0, hs_low = 0, hs_first = -1;
    int vs_low = 0, vs_first = -1, pix_bad = 0, vs_edge_bad = 0;
    int fs3 = 0, de3 = 0, first_idle = -1;
    int h, v;
    logic prev_vs = 1'b1;
    logic [10:0] ex, ey;
    en_m = 1'b1;
    step();
    step();
    for (int k = 0; k < 600; k++) begin
      if (k > 0) step();
      if (!m_run) begin
        first_idle = k;
        break;
      end
      h = k % 15;
      v = (k / 15) % 10;
      ex = (h < 8 && v < 5) ? 11'(h) : 11'd0;
      ey = (h < 8 && v < 5) ? 11'(v) : 11'd0;
      if ({m_px, m_py} !== {ex, ey}) pix_bad++;
      if (m_vs !== prev_vs && h != 0) vs_edge_bad++;
      prev_vs = m_vs;
      if (k < 300) begin
        if (m_de) de_cnt++;
        if (m_fs) fs_cnt++;
        if (m_ls) ls_cnt++;
        if (!m_hs) begin hs_low++; if (hs_first < 0) hs_first = k; end
        if (!m_vs) begin vs_low++; if (vs_first < 0) vs_first = k; end
      end else begin
        if (m_de) de3++;
        if (m_fs && k > 300) fs3++;
      end
      if (k == 345) en_m = 1'b0;
    end
    total++; if (de_cnt != 80) $display("FAIL m_de_count got=%0d exp=80", de_cnt); else passed++;
    total++; if (fs_cnt != 2) $display("FAIL m_frame_starts got=%0d exp=2", fs_cnt); else passed++;
    total++; if (ls_cnt != 20) $display("FAIL m_line_starts got=%0d exp=20", ls_cnt); else passed++;
    total++; if (hs_low != 60 || hs_first != 10)
      $display("FAIL m_hsync got=%0d@%0d exp=60@10", hs_low, hs_first); else passed++;
    total++; if (vs_low != 60 || vs_first != 90)
      $display("FAIL m_vsync got=%0d@%0d exp=60@90", vs_low, vs_first); else passed++;
    total++; if (pix_bad != 0) $display("FAIL m_pix_track got=%0d bad exp=0", pix_bad); else passed++;
    total++; if (vs_edge_bad != 0) $display("FAIL m_vs_align got=%0d exp=0", vs_edge_bad); else passed++;
    total++; if (de3 != 40) $display("FAIL m_stop_frame_de got=%0d exp=40", de3); else passed++;
    total++; if (fs3 != 0) $display("FAIL m_stop_extra_fs got=%0d exp=0", fs3); else passed++;
    total++; if (first_idle != 450) $display("FAIL m_stop_point got=%0d exp=450", first_idle); else passed++;
    total++; if ({m_hs, m_vs, m_de, m_fs, m_px, m_py} !== {4'b1100, 22'd0})
      $display("FAIL m_idle_outputs got=%b exp=1100", {m_hs, m_vs, m_de, m_fs}); else passed++;
    repeat (20) step();
    total++; if ({m_run, m_fs, m_ls} !== 3'b000)
      $display("FAIL m_stays_idle got=%b exp=000", {m_run, m_fs, m_ls}); else passed++;
  endtask

  task automatic test_pulse();
    int fs_cnt = 0, fs_k = -1, de_cnt = 0, first_idle = -1;
    en_m = 1'b1;
    step();
    en_m = 1'b0;
    step();
    for (int k = 0; k < 200; k++) begin
      if (k > 0) step();
      if (m_fs) begin fs_cnt++; if (fs_k < 0) fs_k = k; end
      if (m_de) de_cnt++;
      if (!m_run && first_idle < 0) first_idle = k;
    end
    total++; if (fs_cnt != 1 || fs_k != 0)
      $display("FAIL pulse_frame_start got=%0d@%0d exp=1@0", fs_cnt, fs_k); else passed++;
    total++; if (de_cnt != 40) $display("FAIL pulse_de_count got=%0d exp=40", de_cnt); else passed++;
    total++; if (first_idle != 150) $display("FAIL pulse_idle_at got=%0d exp=150", first_idle); else passed++;
  endtask

  task automatic test_small_scoreboard();
    int h, v;
    logic e_de;
    logic [27:0] got, exp;
    en_s = 1'b1;
    step();
    step();
    for (int k = 0; k < 148; k++) begin
      if (k > 0) step();
      h = k % 8;
      v = (k / 8) % 6;
      e_de = (h < 4) && (v < 3);
      if (k < 144)
        exp = {(h >= 5 && h < 7), (v == 4), e_de, (h == 0), (h == 0 && v == 0), 1'b1,
               e_de ? 11'(h) : 11'd0, e_de ? 11'(v) : 11'd0};
      else
        exp = 28'd0;
      got = {s_hs, s_vs, s_de, s_ls, s_fs, s_run, s_px, s_py};
      total++; if (got !== exp)
        $display("FAIL s_cycle%0d got=%h exp=%h", k, got, exp); else passed++;
      if (k == 110) en_s = 1'b0;
    end
  endtask

  initial begin
    passed = 0;
    total  = 0;
    rst_n  = 1'b0;
    en_d   = 1'b0;
    en_m   = 1'b0;
    en_s   = 1'b0;
    test_reset();
    test_default_lines();
    test_reset_midframe();
    test_frames_and_stop();
    test_pulse();
    test_small_scoreboard();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
